// File: rtl/pong_pkg.sv
// Shared Pong definitions: coordinate/size/velocity widths and the match FSM encoding.
package pong_pkg;

  localparam int COORD_W = 10;
  localparam int SIZE_W  = 5;
  localparam int VEL_W   = 4;
  localparam int SCORE_W = 4;
  localparam int STATE_W = 3;
  localparam int CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_SERVE     = 3'd1,
    ST_PLAY      = 3'd2,
    ST_POINT     = 3'd3,
    ST_GAME_OVER = 3'd4
  } game_state_t;

endpackage

// File: rtl/rally_speed_ctrl.sv
// Counts paddle bounces (x direction reversals) during a rally and steps the x speed up to a ceiling.
module rally_speed_ctrl
  import pong_pkg::*;
#(
  parameter int VEL_INIT      = 2,
  parameter int VEL_MAX       = 8,
  parameter int HITS_PER_STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             x_ball_dir,
  output logic [VEL_W-1:0] x_ball_vel
);

  localparam logic [VEL_W-1:0] VEL_INIT_V = VEL_W'(VEL_INIT);
  localparam logic [VEL_W-1:0] VEL_MAX_V  = VEL_W'(VEL_MAX);
  localparam logic [3:0]       HIT_LAST   = 4'(HITS_PER_STEP - 1);

  function automatic logic [VEL_W-1:0] sat_inc(input logic [VEL_W-1:0] v);
    return (v >= VEL_MAX_V) ? VEL_MAX_V : v + VEL_W'(1);
  endfunction

  logic       dir_q;
  logic [3:0] hit_cnt;
  logic       hit;

  assign hit = enable && (x_ball_dir != dir_q);

  // Direction history is pure data and needs no reset; the counter and speed are control.
  always_ff @(posedge clk) begin
    dir_q <= x_ball_dir;
    if (reset || clear) begin
      hit_cnt    <= '0;
      x_ball_vel <= VEL_INIT_V;
    end else if (hit) begin
      if (hit_cnt == HIT_LAST) begin
        hit_cnt    <= '0;
        x_ball_vel <= sat_inc(x_ball_vel);
      end else begin
        hit_cnt <= hit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Pong match sequencer: serve delay, goal detection, scoring, win detection and ball hold/recentre.
module game_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE     = 7,
  parameter int SERVE_DELAY   = 60,
  parameter int VEL_INIT      = 2,
  parameter int VEL_MAX       = 8,
  parameter int Y_VEL         = 2,
  parameter int HITS_PER_STEP = 4
) (
  input  logic               game_clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] x_ball,
  input  logic [SIZE_W-1:0]  width_ball,
  input  logic               x_ball_dir,
  input  logic [COORD_W-1:0] x_lwall,
  input  logic [COORD_W-1:0] x_rwall,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic [VEL_W-1:0]   x_ball_vel,
  output logic [VEL_W-1:0]   y_ball_vel,
  output logic [SCORE_W-1:0] score_left,
  output logic [SCORE_W-1:0] score_right,
  output logic               winner,
  output logic               game_over,
  output logic [STATE_W-1:0] state
);

  localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_DELAY);
  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);

  game_state_t        cur_state, state_n;
  logic [CNT_W-1:0]   serve_cnt, cnt_n;
  logic [SCORE_W-1:0] sl_n, sr_n;
  logic               dir_n, win_n;
  logic               start_q, start_rise;
  logic               left_goal, right_goal;
  logic [COORD_W:0]   right_edge;
  logic               speed_clear, speed_en;

  // Right edge is formed in 11 bits so a ball near the top of the range cannot wrap past the wall.
  assign right_edge = {1'b0, x_ball} + {{(COORD_W + 1 - SIZE_W){1'b0}}, width_ball};
  assign left_goal  = (x_ball <= x_lwall);
  assign right_goal = (right_edge >= {1'b0, x_rwall});
  assign start_rise = start && !start_q;
  assign state      = cur_state;

  always_comb begin
    state_n     = cur_state;
    cnt_n       = serve_cnt;
    sl_n        = score_left;
    sr_n        = score_right;
    dir_n       = serve_dir;
    win_n       = winner;
    speed_clear = 1'b0;
    speed_en    = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (start) begin
          state_n     = ST_SERVE;
          cnt_n       = SERVE_CNT;
          speed_clear = 1'b1;
        end
      end
      ST_SERVE: begin
        if (serve_cnt == CNT_W'(1)) state_n = ST_PLAY;
        else                        cnt_n   = serve_cnt - CNT_W'(1);
      end
      ST_PLAY: begin
        // Left goal takes priority when both conditions hold; the loser receives the next serve.
        if (left_goal) begin
          sr_n    = score_right + SCORE_W'(1);
          dir_n   = 1'b0;
          state_n = ST_POINT;
        end else if (right_goal) begin
          sl_n    = score_left + SCORE_W'(1);
          dir_n   = 1'b1;
          state_n = ST_POINT;
        end else begin
          speed_en = 1'b1;
        end
      end
      ST_POINT: begin
        if (score_left == WIN_V || score_right == WIN_V) begin
          state_n = ST_GAME_OVER;
          win_n   = (score_right == WIN_V);
        end else begin
          state_n     = ST_SERVE;
          cnt_n       = SERVE_CNT;
          speed_clear = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (start_rise) begin
          sl_n        = '0;
          sr_n        = '0;
          dir_n       = 1'b1;
          state_n     = ST_SERVE;
          cnt_n       = SERVE_CNT;
          speed_clear = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      cur_state   <= ST_IDLE;
      serve_cnt   <= '0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b1;
      winner      <= 1'b0;
      game_over   <= 1'b0;
      ball_hold   <= 1'b1;
      y_ball_vel  <= VEL_W'(Y_VEL);
      start_q     <= 1'b0;
    end else begin
      cur_state   <= state_n;
      serve_cnt   <= cnt_n;
      score_left  <= sl_n;
      score_right <= sr_n;
      serve_dir   <= dir_n;
      winner      <= win_n;
      game_over   <= (state_n == ST_GAME_OVER);
      ball_hold   <= (state_n != ST_PLAY);
      y_ball_vel  <= VEL_W'(Y_VEL);
      start_q     <= start;
    end
  end

  rally_speed_ctrl #(
    .VEL_INIT      (VEL_INIT),
    .VEL_MAX       (VEL_MAX),
    .HITS_PER_STEP (HITS_PER_STEP)
  ) u_speed (
    .clk        (game_clk),
    .reset      (reset),
    .clear      (speed_clear),
    .enable     (speed_en),
    .x_ball_dir (x_ball_dir),
    .x_ball_vel (x_ball_vel)
  );

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters (serve delay 60, win at 7).
module tb_game_sequencer;

  logic       game_clk = 1'b0;
  logic       reset, start, x_ball_dir;
  logic [9:0] x_ball, x_lwall, x_rwall;
  logic [4:0] width_ball;
  logic       ball_hold, serve_dir, winner, game_over;
  logic [3:0] x_ball_vel, y_ball_vel, score_left, score_right;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_POINT = 3, S_OVER = 4;

  game_sequencer dut (
    .game_clk    (game_clk),
    .reset       (reset),
    .start       (start),
    .x_ball      (x_ball),
    .width_ball  (width_ball),
    .x_ball_dir  (x_ball_dir),
    .x_lwall     (x_lwall),
    .x_rwall     (x_rwall),
    .ball_hold   (ball_hold),
    .serve_dir   (serve_dir),
    .x_ball_vel  (x_ball_vel),
    .y_ball_vel  (y_ball_vel),
    .score_left  (score_left),
    .score_right (score_right),
    .winner      (winner),
    .game_over   (game_over),
    .state       (state)
  );

  always #5 game_clk = ~game_clk;

  task automatic tick();
    @(posedge game_clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic serve_wait();
    repeat (60) tick();
    check("serve_to_play", state, S_PLAY);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; x_ball_dir = 1'b0;
    x_ball = 10'd300; width_ball = 5'd10; x_lwall = 10'd8; x_rwall = 10'd605;
    tick(); tick();
    reset = 1'b0;
    check("rst_state", state, S_IDLE);
    check("rst_hold", ball_hold, 1);
    check("rst_serve_dir", serve_dir, 1);
    check("rst_xvel", x_ball_vel, 2);
    check("rst_yvel", y_ball_vel, 2);
    check("rst_scores", {score_left, score_right}, 0);
    check("rst_winner", winner, 0);
    check("rst_game_over", game_over, 0);

    // Start pulse: ball released on the 61st edge counting the start-sampling edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_serve", state, S_SERVE);
    check("start_xvel", x_ball_vel, 2);
    repeat (59) tick();
    check("hold_edge60", ball_hold, 1);
    tick();
    check("hold_edge61", ball_hold, 0);
    check("play_edge61", state, S_PLAY);

    // Near-miss boundaries do not score.
    x_ball = 10'd9; tick();
    check("no_left_goal", state, S_PLAY);
    x_ball = 10'd594; tick();
    check("no_right_goal", state, S_PLAY);

    // Left goal.
    x_ball = 10'd5; tick();
    x_ball = 10'd300;
    check("lg_score_right", score_right, 1);
    check("lg_serve_dir", serve_dir, 0);
    check("lg_state", state, S_POINT);
    check("lg_hold", ball_hold, 1);
    tick();
    check("lg_reserve", state, S_SERVE);
    check("lg_vel", x_ball_vel, 2);
    serve_wait();

    // Rally speed-up: one step per four reversals, saturating at 8.
    for (int i = 0; i < 36; i++) begin
      x_ball_dir = ~x_ball_dir;
      tick();
      if (i == 2)  check("vel_3hits", x_ball_vel, 2);
      if (i == 3)  check("vel_4hits", x_ball_vel, 3);
      if (i == 7)  check("vel_8hits", x_ball_vel, 4);
      if (i == 23) check("vel_24hits", x_ball_vel, 8);
      tick();
    end
    check("vel_saturated", x_ball_vel, 8);

    // Both goals at once: left goal wins.
    x_ball = 10'd5; x_rwall = 10'd10; tick();
    x_ball = 10'd300; x_rwall = 10'd605;
    check("tie_score_right", score_right, 2);
    check("tie_score_left", score_left, 0);
    check("tie_state", state, S_POINT);
    tick();
    check("tie_vel_reload", x_ball_vel, 2);
    serve_wait();

    // Three right goals (exact-equality boundary) to reach 3-2.
    for (int p = 1; p <= 3; p++) begin
      x_ball = 10'd595; tick();
      x_ball = 10'd300;
      check("rg_score_left", score_left, p);
      check("rg_serve_dir", serve_dir, 1);
      tick();
      if (p < 3) serve_wait();
    end
    repeat (10) tick();
    check("mid_serve_state", state, S_SERVE);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_scores", {score_left, score_right}, 0);
    check("rst_mid_state", state, S_IDLE);
    check("rst_mid_hold", ball_hold, 1);
    check("rst_mid_dir", serve_dir, 1);

    // Full match to 7 with start held high throughout.
    start = 1'b1;
    tick();
    check("match_serve", state, S_SERVE);
    for (int p = 1; p <= 7; p++) begin
      serve_wait();
      x_ball = 10'd600; tick();
      x_ball = 10'd300;
      check("match_score_left", score_left, p);
      tick();
      if (p < 7) check("match_reserve", state, S_SERVE);
    end
    check("over_state", state, S_OVER);
    check("over_flag", game_over, 1);
    check("over_winner", winner, 0);
    check("over_hold", ball_hold, 1);
    repeat (5) tick();
    check("held_no_restart", state, S_OVER);
    check("held_scores_frozen", score_left, 7);

    // Fresh rising edge restarts the match.
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("restart_state", state, S_SERVE);
    check("restart_scores", {score_left, score_right}, 0);
    check("restart_game_over", game_over, 0);
    check("restart_dir", serve_dir, 1);
    check("restart_vel", x_ball_vel, 2);
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
